// File: rtl/prefetch_ifu.sv
// Instruction prefetch unit: fetches sequential words over a Wishbone-style
// instruction bus into a small FIFO and presents the head instruction with its
// PC. Taken jumps flush the FIFO and redirect fetching; a request already on
// the bus is allowed to finish and its data is thrown away.
module prefetch_ifu #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] instr_bus_adr,
  input  logic [31:0]     instr_bus_dat_r,
  output logic [31:0]     instr_bus_dat_w,
  output logic            instr_bus_cyc,
  output logic            instr_bus_stb,
  output logic            instr_bus_we,
  output logic [3:0]      instr_bus_sel,
  input  logic            instr_bus_ack,
  input  logic            stall,
  input  logic            je,
  input  logic [XLEN-1:0] ja,
  output logic            out_valid,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] curr_pc,
  output logic [XLEN-1:0] inc_pc
);

  localparam int              PW         = $clog2(DEPTH);
  localparam int              CW         = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C    = CW'(DEPTH);
  localparam logic [31:0]     NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(32'd4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(32'd3);
  localparam logic [PW-1:0]   PTR_ONE    = PW'(1);

  // Registered state
  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] adr_r;
  logic            cyc_r;
  logic            discard_r;
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;
  logic [CW-1:0]   count_r;
  logic [XLEN-1:0] last_pc_r;
  logic [31:0]     instr_mem_r [DEPTH];
  logic [XLEN-1:0] pc_mem_r    [DEPTH];

  // Next-state / decode signals
  logic            ack_s;
  logic            pop_s;
  logic            write_s;
  logic            out_valid_s;
  logic [XLEN-1:0] curr_pc_s;
  logic [XLEN-1:0] fetch_pc_s;
  logic [XLEN-1:0] adr_s;
  logic            cyc_s;
  logic            discard_s;
  logic [PW-1:0]   head_s;
  logic [PW-1:0]   tail_s;
  logic [CW-1:0]   count_s;

  // Head view and transfer qualifiers; a jump overrides both pop and write
  always_comb begin
    out_valid_s = 1'b0;
    curr_pc_s   = last_pc_r;
    ack_s       = cyc_r & instr_bus_ack;
    if (count_r != '0) begin
      out_valid_s = 1'b1;
      curr_pc_s   = pc_mem_r[head_r];
    end else begin
      out_valid_s = 1'b0;
      curr_pc_s   = last_pc_r;
    end
    pop_s   = out_valid_s & ~stall & ~je;
    write_s = ack_s & ~discard_r & ~je;
  end

  // Fetch address, discard flag, FIFO pointers and bus request next state
  always_comb begin
    fetch_pc_s = fetch_pc_r;
    discard_s  = discard_r;
    head_s     = head_r;
    tail_s     = tail_r;
    count_s    = count_r;
    cyc_s      = cyc_r;
    adr_s      = adr_r;

    if (je) begin
      fetch_pc_s = ja & ALIGN_MASK;
    end else if (write_s) begin
      fetch_pc_s = fetch_pc_r + PC_STEP;
    end else begin
      fetch_pc_s = fetch_pc_r;
    end

    // An in-flight request caught by a jump must still complete; mark it stale
    if (ack_s) begin
      discard_s = 1'b0;
    end else if (je && cyc_r) begin
      discard_s = 1'b1;
    end else begin
      discard_s = discard_r;
    end

    if (je) begin
      head_s  = '0;
      tail_s  = '0;
      count_s = '0;
    end else begin
      head_s  = pop_s   ? head_r + PTR_ONE : head_r;
      tail_s  = write_s ? tail_r + PTR_ONE : tail_r;
      count_s = count_r + CW'(write_s) - CW'(pop_s);
    end

    // Hold an open request until ACK; otherwise issue whenever a slot is free
    if (cyc_r && !ack_s) begin
      cyc_s = 1'b1;
      adr_s = adr_r;
    end else if (count_s < DEPTH_C) begin
      cyc_s = 1'b1;
      adr_s = fetch_pc_s;
    end else begin
      cyc_s = 1'b0;
      adr_s = adr_r;
    end
  end

  // Control and bus registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
      adr_r      <= RESET_PC;
      cyc_r      <= 1'b0;
      discard_r  <= 1'b0;
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
      last_pc_r  <= RESET_PC;
    end else begin
      fetch_pc_r <= fetch_pc_s;
      adr_r      <= adr_s;
      cyc_r      <= cyc_s;
      discard_r  <= discard_s;
      head_r     <= head_s;
      tail_r     <= tail_s;
      count_r    <= count_s;
      last_pc_r  <= curr_pc_s;
    end
  end

  // FIFO storage: each entry keeps the fetched word and the address it came from
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i]    <= '0;
      end
    end else if (write_s) begin
      instr_mem_r[tail_r] <= instr_bus_dat_r;
      pc_mem_r[tail_r]    <= adr_r;
    end
  end

  assign instr_bus_adr   = adr_r;
  assign instr_bus_cyc   = cyc_r;
  assign instr_bus_stb   = cyc_r;
  assign instr_bus_we    = 1'b0;
  assign instr_bus_sel   = 4'b1111;
  assign instr_bus_dat_w = 32'h0000_0000;
  assign out_valid       = out_valid_s;
  assign instr_out       = out_valid_s ? instr_mem_r[head_r] : NOP;
  assign curr_pc         = curr_pc_s;
  assign inc_pc          = curr_pc_s + PC_STEP;

endmodule

// File: tb/tb_prefetch_ifu.sv
// Scoreboard bench for prefetch_ifu: directed jumps, stalls and resets; a
// negedge monitor compares every consumed instruction against a queue of
// expected {pc, word, pc+4} entries pushed by the stimulus.
module tb_prefetch_ifu;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] inc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_bus_adr;
  logic [31:0] instr_bus_dat_r;
  logic [31:0] instr_bus_dat_w;
  logic        instr_bus_cyc;
  logic        instr_bus_stb;
  logic        instr_bus_we;
  logic [3:0]  instr_bus_sel;
  logic        instr_bus_ack;
  logic        stall;
  logic        je;
  logic [31:0] ja;
  logic        out_valid;
  logic [31:0] instr_out;
  logic [31:0] curr_pc;
  logic [31:0] inc_pc;

  logic        ack_slv;
  logic        ack_force;
  int          ack_delay;
  int          wait_cnt;
  logic        prev_pend;
  logic [31:0] prev_adr;

  exp_t        sb_q[$];
  logic [31:0] acked_q[$];
  int          checks;
  int          errors;

  prefetch_ifu #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instr_bus_adr   (instr_bus_adr),
    .instr_bus_dat_r (instr_bus_dat_r),
    .instr_bus_dat_w (instr_bus_dat_w),
    .instr_bus_cyc   (instr_bus_cyc),
    .instr_bus_stb   (instr_bus_stb),
    .instr_bus_we    (instr_bus_we),
    .instr_bus_sel   (instr_bus_sel),
    .instr_bus_ack   (instr_bus_ack),
    .stall           (stall),
    .je              (je),
    .ja              (ja),
    .out_valid       (out_valid),
    .instr_out       (instr_out),
    .curr_pc         (curr_pc),
    .inc_pc          (inc_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instr_bus_ack = ack_slv | ack_force;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5A5, a[31:16] ^ 16'h5A5A};
  endfunction

  function automatic logic [31:0] get_ack(input int i);
    if (acked_q.size() > i) return acked_q[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc  = start + 32'(4 * i);
      e.ins = mem_word(e.pc);
      e.inc = e.pc + 32'd4;
      sb_q.push_back(e);
    end
  endtask

  // Called just after a rising edge: release stall until all expected entries are popped
  task automatic drain(input string name);
    int n;
    n = 0;
    stall = 1'b0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    stall = 1'b1;
    check(name, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  // Bus slave: registered ACK after ack_delay extra cycles, one-cycle pulse
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_slv         <= 1'b0;
      wait_cnt        <= 0;
      instr_bus_dat_r <= 32'h0;
    end else if (ack_slv) begin
      ack_slv <= 1'b0;
    end else if (instr_bus_cyc && instr_bus_stb) begin
      if (wait_cnt >= ack_delay) begin
        ack_slv         <= 1'b1;
        instr_bus_dat_r <= mem_word(instr_bus_adr);
        wait_cnt        <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  // Monitor: bus protocol, ACK log, and scoreboard compare of each consumed entry
  always @(negedge clk) begin
    if (rst_n) begin
      check("bus_we_sel", {27'd0, instr_bus_we, instr_bus_sel}, 32'h0000_000F);
      check("bus_dat_w", instr_bus_dat_w, 32'h0);
      check("stb_eq_cyc", {31'd0, instr_bus_stb}, {31'd0, instr_bus_cyc});
      if (prev_pend && instr_bus_cyc) check("adr_hold", instr_bus_adr, prev_adr);
      prev_pend <= instr_bus_cyc && !instr_bus_ack;
      prev_adr  <= instr_bus_adr;
      if (instr_bus_cyc && instr_bus_ack) acked_q.push_back(instr_bus_adr);
      if (out_valid && !stall && !je) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pop_pc", curr_pc, 32'hxxxx_xxxx);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("pop_pc", curr_pc, e.pc);
          check("pop_instr", instr_out, e.ins);
          check("pop_inc_pc", inc_pc, e.inc);
        end
      end
    end else begin
      prev_pend <= 1'b0;
    end
  end

  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    stall     = 1'b1;
    je        = 1'b0;
    ja        = 32'h0;
    ack_force = 1'b0;
    ack_delay = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", {31'd0, instr_bus_cyc}, 32'd0);
    check("rst_stb", {31'd0, instr_bus_stb}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr_out", instr_out, 32'h0000_0013);
    check("rst_curr_pc", curr_pc, 32'h0);
    check("rst_inc_pc", inc_pc, 32'h4);
    ack_force = 1'b1;
    @(posedge clk); #1;
    check("rst_ack_ignored", {31'd0, instr_bus_cyc}, 32'd0);
    ack_force = 1'b0;
    rst_n     = 1'b1;

    // First request on the first edge after release
    @(posedge clk); #1;
    check("first_cyc", {31'd0, instr_bus_cyc}, 32'd1);
    check("first_adr", instr_bus_adr, 32'h0);

    // Stalled: exactly DEPTH requests, then the bus goes idle
    repeat (30) @(posedge clk);
    #1;
    check("stall_req_count", 32'(acked_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("stall_req_adr", get_ack(i), 32'(4 * i));
    check("full_cyc_low", {31'd0, instr_bus_cyc}, 32'd0);
    check("full_head_pc", curr_pc, 32'h0);
    check("full_head_instr", instr_out, mem_word(32'h0));
    acked_q.delete();
    push_seq(32'h0, 16);
    drain("stream_drain");
    check("resume_adr", get_ack(0), 32'h10);

    // Jump while a request to 0x8 is outstanding with a slow slave
    repeat (15) @(posedge clk);
    #1;
    ack_delay = 3;
    je = 1'b1; ja = 32'h0;
    @(posedge clk); #1;
    je = 1'b0;
    n = 0;
    while (!(instr_bus_cyc && instr_bus_adr == 32'h8) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_adr8", instr_bus_adr, 32'h8);
    acked_q.delete();
    je = 1'b1; ja = 32'h103;
    @(posedge clk); #1;
    je = 1'b0;
    check("je_out_valid_0", {31'd0, out_valid}, 32'd0);
    check("je_cyc_held", {31'd0, instr_bus_cyc}, 32'd1);
    check("je_adr_held", instr_bus_adr, 32'h8);
    repeat (40) @(posedge clk);
    #1;
    check("discard_ack_adr", get_ack(0), 32'h8);
    check("redirect_adr", get_ack(1), 32'h100);
    push_seq(32'h100, 4);
    drain("redirect_drain");

    // Jump coinciding with an ACK and a pop while half full; fixed 3-edge latency
    ack_delay = 0;
    repeat (15) @(posedge clk);
    #1;
    je = 1'b1; ja = 32'h200;
    acked_q.delete();
    @(posedge clk); #1;
    je = 1'b0;
    n = 0;
    while (!(instr_bus_ack && acked_q.size() == 2) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("half_full_valid", {31'd0, out_valid}, 32'd1);
    check("half_full_head", curr_pc, 32'h200);
    stall = 1'b0; je = 1'b1; ja = 32'h300;
    @(posedge clk); #1;
    je = 1'b0; stall = 1'b1;
    check("lat_edge1_valid", {31'd0, out_valid}, 32'd0);
    check("lat_edge1_adr", instr_bus_adr, 32'h300);
    check("lat_edge1_cyc", {31'd0, instr_bus_cyc}, 32'd1);
    @(posedge clk); #1;
    check("lat_edge2_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_edge3_valid", {31'd0, out_valid}, 32'd1);
    check("lat_edge3_pc", curr_pc, 32'h300);
    repeat (20) @(posedge clk);
    #1;
    push_seq(32'h300, 4);
    drain("ack_je_drain");

    // Fetch address wrap at the top of the address space
    repeat (15) @(posedge clk);
    #1;
    je = 1'b1; ja = 32'hFFFF_FFFC;
    acked_q.delete();
    @(posedge clk); #1;
    je = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("wrap_adr0", get_ack(0), 32'hFFFF_FFFC);
    check("wrap_adr1", get_ack(1), 32'h0);
    check("wrap_inc_pc", inc_pc, 32'h0);
    sb_q.push_back('{pc: 32'hFFFF_FFFC, ins: mem_word(32'hFFFF_FFFC), inc: 32'h0});
    push_seq(32'h0, 3);
    drain("wrap_drain");

    // Reset in the middle of a held request
    repeat (15) @(posedge clk);
    #1;
    ack_delay = 5;
    je = 1'b1; ja = 32'h500;
    @(posedge clk); #1;
    je = 1'b0;
    check("mid_cyc", {31'd0, instr_bus_cyc}, 32'd1);
    check("mid_adr", instr_bus_adr, 32'h500);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_cyc_low", {31'd0, instr_bus_cyc}, 32'd0);
    check("async_stb_low", {31'd0, instr_bus_stb}, 32'd0);
    check("async_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_instr_out", instr_out, 32'h0000_0013);
    check("async_curr_pc", curr_pc, 32'h0);
    check("async_inc_pc", inc_pc, 32'h4);
    ack_delay = 0;
    @(posedge clk); #1;
    ack_force = 1'b1;
    @(posedge clk); #1;
    check("late_ack_ignored", {31'd0, instr_bus_cyc}, 32'd0);
    ack_force = 1'b0;
    acked_q.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("restart_cyc", {31'd0, instr_bus_cyc}, 32'd1);
    check("restart_adr", instr_bus_adr, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    check("restart_first_ack", get_ack(0), 32'h0);
    push_seq(32'h0, 4);
    drain("restart_drain");

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefetch_ifu.md
PREFETCH_IFU -- requirements
Module: prefetch_ifu

Interface
REQ-001 Parameter XLEN, default 32: width of PCs and bus address.
REQ-002 Parameter DEPTH, default 4: prefetch buffer entries; power of two, >= 2.
REQ-003 Parameter RESET_PC, default 0: first fetch address after reset; bits [1:0] SHALL be 0.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 instr_bus  wishbone.MASTER  -  instruction bus (ADR XLEN, DAT_R 32, CYC, STB, ACK, WE, SEL, DAT_W).
REQ-008 stall  input  1  downstream not ready; head entry SHALL NOT be consumed while high.
REQ-009 je  input  1  jump/branch taken; redirect fetch.
REQ-010 ja  input  XLEN  jump target, sampled when je=1.
REQ-011 out_valid  output  1  buffer head holds a valid instruction.
REQ-012 instr_out  output  32  head instruction word.
REQ-013 curr_pc  output  XLEN  PC of head instruction.
REQ-014 inc_pc  output  XLEN  curr_pc + 4, modulo 2^XLEN.

Function
REQ-015 WE SHALL be 0, DAT_W SHALL be 0 and SEL SHALL be 4'b1111 at all times.
REQ-016 The block SHALL hold a fetch address register fetch_pc and at most one outstanding bus request.
REQ-017 Issue: with no request outstanding and (occupancy < DEPTH), CYC=STB=1, ADR=fetch_pc; CYC/STB SHALL stay high and ADR stable until ACK.
REQ-018 On ACK with no pending discard: write {DAT_R, ADR} to tail; fetch_pc += 4 (wraps at 2^XLEN); CYC/STB drop for at least one cycle only if the buffer becomes full.
REQ-019 Back-to-back fetches SHALL be allowed: a new request MAY assert the cycle after ACK if room remains, giving 1 fetch/2 cycles minimum throughput.
REQ-020 out_valid = (occupancy != 0); when 0, instr_out SHALL be 32'h0000_0013 (NOP) and curr_pc SHALL hold its last value.
REQ-021 Consume: out_valid=1 and stall=0 and je=0 pops the head at the clock edge.
REQ-022 Simultaneous ACK-write and pop SHALL leave occupancy unchanged; write when full SHALL never occur (REQ-017 guarantees).
REQ-023 Head/tail pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; occupancy SHALL be log2(DEPTH)+1 bits.
REQ-024 On je=1: buffer emptied, fetch_pc <= {ja[XLEN-1:2], 2'b00}, out_valid=0 the next cycle; je takes priority over pop and ACK-write in the same cycle.
REQ-025 je while a request is outstanding: request SHALL complete (CYC/STB held to ACK) and its data SHALL be discarded (discard flag); first request to the new target issues the cycle after that ACK.
REQ-026 je in the same cycle as ACK: ACK data discarded, no discard flag set, new-target request MAY issue next cycle.
REQ-027 A second je while discard flag set SHALL overwrite fetch_pc; flag remains until the single outstanding ACK.
REQ-028 Latency: from je to out_valid with ACK in 1 cycle and no outstanding request = 3 clock edges.

Reset
REQ-029 While rst_n=0: CYC=STB=0, buffer empty, out_valid=0, instr_out=32'h0000_0013, fetch_pc=RESET_PC, curr_pc=RESET_PC, inc_pc=RESET_PC+4, discard flag 0.
REQ-030 Reset asserted mid-transaction SHALL drop CYC/STB immediately; any later ACK SHALL be ignored.
REQ-031 First request SHALL issue on the first rising edge after rst_n deasserts, ADR=RESET_PC.

Verification
REQ-032 Reset release, slave ACKs every request in 1 cycle, stall=0 -> ADR 0,4,8,...; instr_out stream matches memory; curr_pc 0,4,8.
REQ-033 stall=1 held, DEPTH=4 -> exactly 4 requests issued, then CYC=0; release stall -> 4 entries drain in order, fetching resumes at 0x10.
REQ-034 je=1, ja=0x103 while request to 0x8 outstanding, ACK delayed 3 cycles -> 0x8 data discarded, next ADR=0x100, first out instr curr_pc=0x100.
REQ-035 je same cycle as ACK and pop with buffer half full -> buffer empty next cycle, no stale instruction ever has out_valid=1.
REQ-036 fetch_pc=0xFFFF_FFFC (XLEN=32) -> next ADR 0x0, inc_pc=0x0 for that entry.
REQ-037 rst_n pulsed low during held STB -> CYC/STB low asynchronously; late ACK ignored; restart at RESET_PC.
